// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, stop period, all timed in 16x sample_ticks.
// A small FIFO in front of the framer lets the producer queue words while a frame is on the line.
module uart_transmitter #(
  parameter int DATA_BITS = 8,
  parameter int STOP_TICK = 16,
  parameter int FIFO_AW   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 sample_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data_in,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [FIFO_AW:0]     fifo_count
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]           tick;
  logic [BW-1:0]        nbits;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 push, pop;

  assign tx_ready  = (fifo_count != (FIFO_AW+1)'(DEPTH));
  assign push      = tx_valid & tx_ready;
  // Pop looks only at the registered count, so a word pushed this cycle is not seen until the next.
  assign pop       = (state == IDLE) && (fifo_count != '0);
  assign shift_nxt = shift >> 1;

  always_ff @(posedge CLK) begin
    if (push && !RESET) mem[wr_ptr] <= tx_data_in;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      tick    <= '0;
      nbits   <= '0;
      shift   <= '0;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          if (pop) begin
            shift   <= mem[rd_ptr];
            tick    <= '0;
            state   <= START;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: if (sample_tick) begin
          if (tick == 5'd15) begin
            tick   <= '0;
            nbits  <= '0;
            state  <= DATA;
            tx_out <= shift[0];
          end else tick <= tick + 5'd1;
        end
        DATA: if (sample_tick) begin
          if (tick == 5'd15) begin
            tick  <= '0;
            shift <= shift_nxt;
            if (nbits == BW'(DATA_BITS-1)) begin
              state  <= STOP;
              tx_out <= 1'b1;
            end else begin
              nbits  <= nbits + BW'(1);
              tx_out <= shift_nxt[0];
            end
          end else tick <= tick + 5'd1;
        end
        STOP: if (sample_tick) begin
          if (tick == 5'(STOP_TICK-1)) begin
            tick    <= '0;
            state   <= IDLE;
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            tx_out  <= 1'b1;
          end else tick <= tick + 5'd1;
        end
        default: begin
          state   <= IDLE;
          tick    <= '0;
          nbits   <= '0;
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboarded bench for uart_transmitter: a tick-level line monitor rebuilds each frame and
// compares it with the words queued by the stimulus; a second instance covers a 2-stop-bit config.
module tb_uart_transmitter;
  localparam int D  = 8;
  localparam int ST = 16;
  localparam int AW = 2;
  localparam int N  = 16*(D+1) + ST;

  logic CLK = 0, RESET = 1, sample_tick = 0, tx_valid = 0, tx_valid2 = 0;
  logic [D-1:0] tx_data_in = '0, tx_data2 = '0;
  logic tx_ready, tx_out, tx_busy, tx_done;
  logic tx_ready2, tx_out2, tx_busy2, tx_done2;
  logic [AW:0] fifo_count, fifo_count2;

  uart_transmitter #(.DATA_BITS(D), .STOP_TICK(ST), .FIFO_AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .sample_tick(sample_tick), .tx_valid(tx_valid),
    .tx_data_in(tx_data_in), .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_count(fifo_count));

  uart_transmitter #(.DATA_BITS(D), .STOP_TICK(32), .FIFO_AW(AW)) dut2 (
    .CLK(CLK), .RESET(RESET), .sample_tick(sample_tick), .tx_valid(tx_valid2),
    .tx_data_in(tx_data2), .tx_ready(tx_ready2), .tx_out(tx_out2), .tx_busy(tx_busy2),
    .tx_done(tx_done2), .fifo_count(fifo_count2));

  always #5 CLK = ~CLK;

  int checks = 0, fails = 0, spurious = 0;
  int tick_div = 4, tc = 0;
  logic [D-1:0] exp_q[$];
  bit rst_pend = 0, mon_active = 0, wait_done = 0, glitch = 0;
  int mon_tick = 0, clks = 0;
  logic [D-1:0] got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Periodic 1-CLK tick strobe, changed just after each rising edge.
  initial forever begin
    @(posedge CLK); #1;
    tc = (tc + 1 >= tick_div) ? 0 : tc + 1;
    sample_tick = (tc == 0);
  end

  always @(posedge CLK) rst_pend = RESET;

  // Monitor: tick n of a frame lies in bit n/16; bit 0 is start, 1..D data, the rest stop.
  initial forever begin
    @(negedge CLK);
    if (rst_pend) begin
      mon_active = 0; wait_done = 0;
      if (tx_done) spurious++;
    end else if (wait_done) begin
      clks++;
      chk("done_pulse", tx_done, 1);
      chk("busy_after_stop", tx_busy, 0);
      checks++;
      if (clks < (N-1)*tick_div + 1 || clks > N*tick_div) begin
        fails++;
        $display("FAIL frame_clks actual=%0d required=%0d..%0d", clks, (N-1)*tick_div+1, N*tick_div);
      end
      chk("frame_line_shape", glitch, 0);
      if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
      else chk("frame_data", got, exp_q.pop_front());
      wait_done = 0; mon_active = 0;
    end else begin
      if (!mon_active) begin
        if (tx_done) spurious++;
        if (tx_out == 1'b0) begin
          mon_active = 1; mon_tick = 0; clks = 0; got = '0;
          glitch = !tx_busy;
        end
      end else clks++;
      if (mon_active) begin
        glitch |= (tx_done !== 1'b0);
        if (sample_tick) begin
          int b;
          b = mon_tick / 16;
          if (b == 0) glitch |= (tx_out !== 1'b0);
          else if (b <= D) begin
            if (mon_tick % 16 == 0) got[b-1] = tx_out;
            else glitch |= (tx_out !== got[b-1]);
          end else glitch |= (tx_out !== 1'b1);
          glitch |= (tx_busy !== 1'b1);
          mon_tick++;
          if (mon_tick == N) wait_done = 1;
        end
      end
    end
  end

  // Caller sits at a negedge; returns at the following negedge with valid dropped.
  task automatic push(input logic [D-1:0] d);
    int n = 0;
    while (!tx_ready && n < 5000) begin @(negedge CLK); n++; end
    if (n >= 5000) chk("push_ready_timeout", 1, 0);
    tx_valid = 1; tx_data_in = d; exp_q.push_back(d);
    @(negedge CLK);
    tx_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || tx_busy || fifo_count != 0) && n < budget) begin
      @(negedge CLK); n++;
    end
    if (n >= budget) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_fifo_count", fifo_count, 0);
    RESET = 0;

    // Single 0xA5 frame, tick every 4 CLKs
    push(8'hA5);
    wait_idle(3000);

    // Fill the FIFO on consecutive CLKs
    for (int i = 1; i <= 5; i++) push(D'(i));
    chk("full_tx_ready", tx_ready, 0);
    chk("full_fifo_count", fifo_count, 4);
    wait_idle(8000);

    // Two stop bits on the second instance
    begin
      int n = 0, ticks = 0, hi = 0;
      tx_valid2 = 1; tx_data2 = 8'h00;
      @(negedge CLK); tx_valid2 = 0;
      while (tx_out2 && n < 2000) begin @(negedge CLK); n++; end
      while (!tx_done2 && n < 2000) begin
        if (sample_tick) begin ticks++; if (tx_out2) hi++; end
        @(negedge CLK); n++;
      end
      chk("st32_frame_ticks", ticks, 176);
      chk("st32_stop_ticks", hi, 32);
    end

    // Reset during data bit 3 with two words queued
    push(8'h5A); push(8'hC3); push(8'h81);
    begin
      int n = 0;
      while (!(mon_active && mon_tick >= 66 && mon_tick <= 76) && n < 3000) begin @(negedge CLK); n++; end
      chk("reached_bit3", (n < 3000), 1);
    end
    RESET = 1; exp_q.delete();
    @(negedge CLK);
    RESET = 0;
    chk("midrst_tx_out", tx_out, 1);
    chk("midrst_fifo_count", fifo_count, 0);
    chk("midrst_tx_busy", tx_busy, 0);
    chk("midrst_tx_done", tx_done, 0);
    repeat (200) @(negedge CLK);
    push(8'h3C);
    wait_idle(3000);

    // Push in the same CLK as an IDLE pop
    push(8'h11); push(8'h22);
    begin
      int n = 0;
      while (!tx_done && n < 3000) begin @(negedge CLK); n++; end
    end
    chk("idle_count_before", fifo_count, 1);
    push(8'h33);
    chk("pushpop_count", fifo_count, 1);
    wait_idle(6000);

    // Randomized traffic at two tick rates
    for (int pass = 0; pass < 2; pass++) begin
      tick_div = (pass == 0) ? 1 : 3;
      for (int i = 0; i < 14; i++) begin
        repeat ($urandom_range(0, 40)) @(negedge CLK);
        push(D'($urandom));
      end
      wait_idle(20000);
    end

    chk("no_spurious_done", spurious, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
